// File: rtl/ag6502_bus_pkg.sv
// Shared definitions for the ag6502 bus timer: register offsets, flag and
// control bit positions, and read-back formatting helpers.
package ag6502_bus_pkg;

  localparam logic [2:0] OFF_T1CL = 3'd0;
  localparam logic [2:0] OFF_T1CH = 3'd1;
  localparam logic [2:0] OFF_T1LL = 3'd2;
  localparam logic [2:0] OFF_T1LH = 3'd3;
  localparam logic [2:0] OFF_ACR  = 3'd4;
  localparam logic [2:0] OFF_IFR  = 3'd5;
  localparam logic [2:0] OFF_IER  = 3'd6;
  localparam logic [2:0] OFF_T2   = 3'd7;

  localparam int IFR_T1  = 0;
  localparam int IFR_T2  = 1;
  localparam int IFR_IRQ = 7;

  localparam int ACR_T1_CONT = 0;
  localparam int ACR_T2_EN   = 1;
  localparam int ACR_PB7     = 7;

  // IFR as seen by the CPU: flags in the low bits, summary bit on top
  function automatic logic [7:0] ifr_read(input logic [1:0] ifr, input logic [1:0] ier);
    logic [7:0] v;
    v = 8'h00;
    v[IFR_T1]  = ifr[IFR_T1];
    v[IFR_T2]  = ifr[IFR_T2];
    v[IFR_IRQ] = |(ifr & ier);
    return v;
  endfunction

  // IER always reads back with bit 7 set
  function automatic logic [7:0] ier_read(input logic [1:0] ier);
    return {1'b1, 5'b00000, ier};
  endfunction

endpackage

// File: rtl/ag6502_timer16.sv
// 16-bit down-counter for timer T1: bus load, continuous reload from the
// latch, or one-shot wrap to FFFF that flags only once per arming.
module ag6502_timer16
  import ag6502_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic [15:0] reload_val,
  input  logic        continuous,
  output logic [15:0] count,
  output logic        expire,
  output logic        reload
);

  logic [15:0] count_r;
  logic [15:0] count_nx_s;
  logic        armed_r;
  logic        armed_nx_s;

  // Next count and expiry pulses; a bus load suppresses any expiry
  always_comb begin
    count_nx_s = count_r;
    armed_nx_s = armed_r;
    expire     = 1'b0;
    reload     = 1'b0;
    if (load) begin
      count_nx_s = load_val;
      armed_nx_s = 1'b1;
    end else if (count_r != 16'h0000) begin
      count_nx_s = count_r - 16'h0001;
    end else if (continuous) begin
      count_nx_s = reload_val;
      expire     = 1'b1;
      reload     = 1'b1;
    end else begin
      count_nx_s = 16'hFFFF;
      expire     = armed_r;
      armed_nx_s = 1'b0;
    end
  end

  // Counter and armed-bit state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= 16'hFFFF;
      armed_r <= 1'b0;
    end else begin
      count_r <= count_nx_s;
      armed_r <= armed_nx_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/ag6502_bus_timer.sv
// Memory-mapped interval timer for the ag6502 bus: T1 (16-bit, reloadable),
// T2 (8-bit one-shot), 6522-style IFR/IER, registered active-low irq.
// Optional PB7 square-wave output is enabled with AG6502_TIMER_PB7_EN.
module ag6502_bus_timer
  import ag6502_bus_pkg::*;
#(
  parameter logic [15:0] BASE           = 16'hC080,
  parameter int          IRQ_OPEN_DRAIN = 0
) (
  input  logic        phi_2,
  input  logic        rst,
  input  logic [15:0] ab,
  input  logic        read,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        sel,
`ifdef AG6502_TIMER_PB7_EN
  output logic        pb7,
`endif
  output logic        irq
);

  logic [15:0] latch_r, latch_nx_s;
  logic [7:0]  acr_r, acr_nx_s;
  logic [1:0]  ifr_r, ifr_nx_s;
  logic [1:0]  ier_r, ier_nx_s;
  logic [7:0]  t2_r, t2_nx_s;
  logic        t2_armed_r, t2_armed_nx_s;
  logic [7:0]  rdata_r, rdata_nx_s;
  logic        irq_act_r;
  logic        wr_s, rd_s, t2_wr_s;
  logic        t1_load_s, t1_expire_s, t1_reload_s;
  logic [15:0] t1_count_s;

  assign sel     = (ab[15:3] == BASE[15:3]);
  assign wr_s    = sel & ~read;
  assign rd_s    = sel & read;
  assign t2_wr_s = wr_s & (ab[2:0] == OFF_T2);

  ag6502_timer16 u_t1 (
    .clk        (phi_2),
    .rst        (rst),
    .load       (t1_load_s),
    .load_val   ({wdata, latch_r[7:0]}),
    .reload_val (latch_nx_s),
    .continuous (acr_r[ACR_T1_CONT]),
    .count      (t1_count_s),
    .expire     (t1_expire_s),
    .reload     (t1_reload_s)
  );

  // Bus decode, T2 counting and flag priority; flag sets are applied last
  always_comb begin
    latch_nx_s    = latch_r;
    acr_nx_s      = acr_r;
    ifr_nx_s      = ifr_r;
    ier_nx_s      = ier_r;
    t2_nx_s       = t2_r;
    t2_armed_nx_s = t2_armed_r;
    rdata_nx_s    = rdata_r;
    t1_load_s     = 1'b0;
    if (wr_s) begin
      case (ab[2:0])
        OFF_T1CL: latch_nx_s[7:0] = wdata;
        OFF_T1CH: begin
          latch_nx_s[15:8] = wdata;
          t1_load_s        = 1'b1;
          ifr_nx_s[IFR_T1] = 1'b0;
        end
        OFF_T1LL: latch_nx_s[7:0]  = wdata;
        OFF_T1LH: latch_nx_s[15:8] = wdata;
        OFF_ACR: begin
          acr_nx_s              = 8'h00;
          acr_nx_s[ACR_T1_CONT] = wdata[ACR_T1_CONT];
          acr_nx_s[ACR_T2_EN]   = wdata[ACR_T2_EN];
`ifdef AG6502_TIMER_PB7_EN
          acr_nx_s[ACR_PB7]     = wdata[ACR_PB7];
`else
          acr_nx_s[ACR_PB7]     = 1'b0;
`endif
        end
        OFF_IFR: ifr_nx_s = ifr_r & ~wdata[1:0];
        OFF_IER: begin
          if (wdata[7]) begin
            ier_nx_s = ier_r | wdata[1:0];
          end else begin
            ier_nx_s = ier_r & ~wdata[1:0];
          end
        end
        OFF_T2: begin
          t2_nx_s          = wdata;
          t2_armed_nx_s    = 1'b1;
          ifr_nx_s[IFR_T2] = 1'b0;
        end
        default: ;
      endcase
    end else if (rd_s) begin
      case (ab[2:0])
        OFF_T1CL: begin
          rdata_nx_s       = t1_count_s[7:0];
          ifr_nx_s[IFR_T1] = 1'b0;
        end
        OFF_T1CH: rdata_nx_s = t1_count_s[15:8];
        OFF_T1LL: rdata_nx_s = latch_r[7:0];
        OFF_T1LH: rdata_nx_s = latch_r[15:8];
        OFF_ACR:  rdata_nx_s = acr_r;
        OFF_IFR:  rdata_nx_s = ifr_read(ifr_r, ier_r);
        OFF_IER:  rdata_nx_s = ier_read(ier_r);
        OFF_T2: begin
          rdata_nx_s       = t2_r;
          ifr_nx_s[IFR_T2] = 1'b0;
        end
        default: rdata_nx_s = 8'h00;
      endcase
    end else begin
      rdata_nx_s = rdata_r;
    end

    if (!t2_wr_s && acr_r[ACR_T2_EN]) begin
      t2_nx_s = t2_r - 8'h01;
      if ((t2_r == 8'h00) && t2_armed_r) begin
        ifr_nx_s[IFR_T2] = 1'b1;
        t2_armed_nx_s    = 1'b0;
      end else begin
        t2_armed_nx_s = t2_armed_nx_s;
      end
    end else begin
      t2_nx_s = t2_nx_s;
    end

    if (t1_expire_s) begin
      ifr_nx_s[IFR_T1] = 1'b1;
    end else begin
      ifr_nx_s[IFR_T1] = ifr_nx_s[IFR_T1];
    end
  end

  // Register file, read data and registered interrupt level
  always_ff @(posedge phi_2 or negedge rst) begin
    if (!rst) begin
      latch_r    <= 16'hFFFF;
      acr_r      <= 8'h00;
      ifr_r      <= 2'b00;
      ier_r      <= 2'b00;
      t2_r       <= 8'h00;
      t2_armed_r <= 1'b0;
      rdata_r    <= 8'h00;
      irq_act_r  <= 1'b0;
    end else begin
      latch_r    <= latch_nx_s;
      acr_r      <= acr_nx_s;
      ifr_r      <= ifr_nx_s;
      ier_r      <= ier_nx_s;
      t2_r       <= t2_nx_s;
      t2_armed_r <= t2_armed_nx_s;
      rdata_r    <= rdata_nx_s;
      irq_act_r  <= |(ifr_r & ier_r);
    end
  end

`ifdef AG6502_TIMER_PB7_EN
  logic pb7_r;

  // PB7 square wave: toggles on each continuous reload, cleared by a T1CH write
  always_ff @(posedge phi_2 or negedge rst) begin
    if (!rst) begin
      pb7_r <= 1'b1;
    end else if (t1_load_s && acr_r[ACR_PB7]) begin
      pb7_r <= 1'b0;
    end else if (t1_reload_s && acr_r[ACR_PB7] && acr_r[ACR_T1_CONT]) begin
      pb7_r <= ~pb7_r;
    end else begin
      pb7_r <= pb7_r;
    end
  end

  assign pb7 = pb7_r;
`endif

  assign rdata = rdata_r;
  assign irq   = irq_act_r ? 1'b0 : ((IRQ_OPEN_DRAIN != 0) ? 1'bz : 1'b1);

endmodule
